// File: rtl/data_memory_pkg.sv
// Shared definitions for the data-memory responder.
//   - default address/data widths used by the top and its interface
//   - MMIO window layout: offsets below the all-ones address and the
//     region-select bit helper
//   - console byte width
//   - decode selector enum
package data_memory_pkg;

  localparam int ADDR   = 16;
  localparam int W_OPR  = 32;
  localparam int CONS_W = 8;

  // MMIO registers sit at the very top of the address space, expressed as
  // offsets below all-ones so they move with the address width.
  localparam int TXDATA_OFS = 15;  // 0xFFF0 at 16 bits
  localparam int TXSTAT_OFS = 14;  // 0xFFF1
  localparam int CYCLE_OFS  = 13;  // 0xFFF2

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_TXDATA,
    SEL_TXSTAT,
    SEL_CYCLE,
    SEL_NONE
  } dm_sel_e;

  // The MSB of the word address selects the MMIO half of the space.
  function automatic int mmio_sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Load/store port plus console transmit handshake.
//   slave  : the data memory (consumes ldst request, drives read data,
//            stall and the console head)
//   master : the execute stage / host side
// Signals:
//   ldst_addr_i, ldst_write_i, ldst_data_i, hold_i : request from pipeline
//   ldst_data_o, stall_o                           : response to pipeline
//   tx_valid_o, tx_data_o, tx_ready_i              : console FIFO head
interface data_memory_if #(
  parameter int ADDR   = data_memory_pkg::ADDR,
  parameter int W_OPR  = data_memory_pkg::W_OPR,
  parameter int CONS_W = data_memory_pkg::CONS_W
);
  logic [ADDR-1:0]   ldst_addr_i;
  logic              ldst_write_i;
  logic [W_OPR-1:0]  ldst_data_i;
  logic [W_OPR-1:0]  ldst_data_o;
  logic              hold_i;
  logic              stall_o;
  logic              tx_valid_o;
  logic [CONS_W-1:0] tx_data_o;
  logic              tx_ready_i;

  modport slave (
    input  ldst_addr_i, ldst_write_i, ldst_data_i, hold_i, tx_ready_i,
    output ldst_data_o, stall_o, tx_valid_o, tx_data_o
  );

  modport master (
    output ldst_addr_i, ldst_write_i, ldst_data_i, hold_i, tx_ready_i,
    input  ldst_data_o, stall_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/data_memory_tx_fifo.sv
// Console transmit FIFO: circular buffer with read/write pointers and an
// occupancy count. Storage is not reset; pointers and count are.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   i_push, i_data  : write request and byte (ignored when full)
//   i_pop           : remove head (ignored when empty)
//   o_data          : head entry, 0 when empty
//   o_full, o_empty : occupancy flags
//   o_count         : number of entries, 0..2**DEPTH_LOG2
module dmem_tx_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count
);
  localparam int                L_DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] L_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      r_mem [L_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_count == L_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_pop)  r_rptr <= r_rptr + DEPTH_LOG2'(1);
      r_count <= r_count + (DEPTH_LOG2+1)'(w_push) - (DEPTH_LOG2+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/data_memory.sv
// Word-addressed data memory on the execute-stage load/store port.
// Returns registered read data one cycle after the address, decodes an MMIO
// window (console TX FIFO, console status, free-running cycle counter) and
// stalls a console store that meets a full FIFO.
// Ports:
//   clk   : clock
//   reset : asynchronous, active-low
//   bus   : data_memory_if.slave (load/store request/response, console head)
module data_memory #(
  parameter int ADDR       = data_memory_pkg::ADDR,
  parameter int W_OPR      = data_memory_pkg::W_OPR,
  parameter int DEPTH_LOG2 = 10,
  parameter int TXQ_LOG2   = 2
) (
  input logic          clk,
  input logic          reset,
  data_memory_if.slave bus
);
  import data_memory_pkg::*;

  localparam int            L_SEL_BIT = mmio_sel_bit(ADDR);
  localparam logic [ADDR-1:0] L_TXDATA = {ADDR{1'b1}} - ADDR'(TXDATA_OFS);
  localparam logic [ADDR-1:0] L_TXSTAT = {ADDR{1'b1}} - ADDR'(TXSTAT_OFS);
  localparam logic [ADDR-1:0] L_CYCLE  = {ADDR{1'b1}} - ADDR'(CYCLE_OFS);

  logic [W_OPR-1:0]      r_ram [2 ** DEPTH_LOG2];
  logic [W_OPR-1:0]      r_rdata_p1;
  logic [31:0]           r_cycle;

  dm_sel_e               w_sel;
  logic [DEPTH_LOG2-1:0] w_ram_idx;
  logic                  w_ram_we;
  logic [W_OPR-1:0]      w_ram_rd;
  logic [W_OPR-1:0]      w_rdata;
  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [TXQ_LOG2:0]     w_count;
  logic [CONS_W-1:0]     w_head;

  always_comb begin
    w_sel = SEL_RAM;
    if (bus.ldst_addr_i[L_SEL_BIT]) begin
      if      (bus.ldst_addr_i == L_TXDATA) w_sel = SEL_TXDATA;
      else if (bus.ldst_addr_i == L_TXSTAT) w_sel = SEL_TXSTAT;
      else if (bus.ldst_addr_i == L_CYCLE)  w_sel = SEL_CYCLE;
      else                                  w_sel = SEL_NONE;
    end
  end

  // No pop-to-push bypass: a full FIFO stalls the store even if the host
  // drains the head in the same cycle.
  assign w_push_req  = bus.ldst_write_i & (w_sel == SEL_TXDATA);
  assign bus.stall_o = w_push_req & w_full;
  assign w_push      = w_push_req & ~w_full;
  assign w_pop       = bus.tx_ready_i & ~w_empty;

  dmem_tx_fifo #(
    .DEPTH_LOG2 (TXQ_LOG2),
    .WIDTH      (CONS_W)
  ) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (bus.ldst_data_i[CONS_W-1:0]),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.tx_valid_o = ~w_empty;
  assign bus.tx_data_o  = w_head;

  // RAM: stores are never stalled here, so the write enable only needs the
  // region check. Read-during-write forwards the store data (write-first).
  assign w_ram_idx = bus.ldst_addr_i[DEPTH_LOG2-1:0];
  assign w_ram_we  = bus.ldst_write_i & (w_sel == SEL_RAM);
  assign w_ram_rd  = w_ram_we ? bus.ldst_data_i : r_ram[w_ram_idx];

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_idx] <= bus.ldst_data_i;
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_RAM:    w_rdata = w_ram_rd;
      SEL_TXSTAT: w_rdata = W_OPR'({w_count, w_full, w_empty});
      SEL_CYCLE:  w_rdata = W_OPR'(r_cycle);
      default:    w_rdata = '0;
    endcase
  end

  // Counter is 0 during the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end

  // ---- stage p0 -> p1: registered read data, frozen while hold_i
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           r_rdata_p1 <= '0;
    else if (!bus.hold_i) r_rdata_p1 <= w_rdata;
  end

  assign bus.ldst_data_o = r_rdata_p1;

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  data_memory_if #(.ADDR(16), .W_OPR(32), .CONS_W(8)) bus ();

  data_memory #(
    .ADDR       (16),
    .W_OPR      (32),
    .DEPTH_LOG2 (10),
    .TXQ_LOG2   (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ldst_addr_i  = 16'h0000;
    bus.ldst_write_i = 1'b0;
    bus.ldst_data_i  = 32'h0;
    bus.hold_i       = 1'b0;
    bus.tx_ready_i   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    tick();
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h0) begin
      errors++; $display("FAIL reset_rdata got %h want %h", bus.ldst_data_o, 32'h0);
    end
    checks++;
    if (bus.tx_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_txvalid got %b want 0", bus.tx_valid_o);
    end
    checks++;
    if (bus.tx_data_o !== 8'h00) begin
      errors++; $display("FAIL reset_txdata got %h want 00", bus.tx_data_o);
    end
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b want 0", bus.stall_o);
    end
  endtask

  // Must run directly after test_reset: release happens here.
  task automatic test_cycle();
    bus.ldst_addr_i = 16'hFFF2;
    reset = 1'b1;
    tick();  // edge 1
    checks++;
    if (bus.ldst_data_o !== 32'd0) begin
      errors++; $display("FAIL cycle_first got %0d want 0", bus.ldst_data_o);
    end
    for (int k = 2; k <= 10; k++) tick();
    checks++;
    if (bus.ldst_data_o !== 32'd9) begin
      errors++; $display("FAIL cycle_tenth got %0d want 9", bus.ldst_data_o);
    end
    idle();
  endtask

  task automatic test_store_load();
    bus.ldst_addr_i = 16'h0010; bus.ldst_write_i = 1'b1; bus.ldst_data_i = 32'hDEADBEEF;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rdw_first got %h want %h", bus.ldst_data_o, 32'hDEADBEEF);
    end
    bus.ldst_write_i = 1'b0; bus.ldst_data_i = 32'h0;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'hDEADBEEF) begin
      errors++; $display("FAIL store_load got %h want %h", bus.ldst_data_o, 32'hDEADBEEF);
    end
  endtask

  task automatic test_hold();
    bus.ldst_addr_i = 16'h0020; bus.ldst_write_i = 1'b1; bus.ldst_data_i = 32'h12345678;
    tick();
    bus.ldst_addr_i = 16'h0021; bus.ldst_data_i = 32'hCAFEF00D;
    tick();
    bus.ldst_write_i = 1'b0; bus.ldst_addr_i = 16'h0020; bus.ldst_data_i = 32'h0;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h12345678) begin
      errors++; $display("FAIL hold_load got %h want %h", bus.ldst_data_o, 32'h12345678);
    end
    bus.hold_i = 1'b1; bus.ldst_addr_i = 16'h0021;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.ldst_data_o !== 32'h12345678) begin
        errors++; $display("FAIL hold_frozen[%0d] got %h want %h", k, bus.ldst_data_o, 32'h12345678);
      end
    end
    bus.hold_i = 1'b0;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'hCAFEF00D) begin
      errors++; $display("FAIL hold_release got %h want %h", bus.ldst_data_o, 32'hCAFEF00D);
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] exp_b;
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.ldst_addr_i = 16'hFFF0; bus.ldst_write_i = 1'b1; bus.ldst_data_i = 32'h41 + 32'(i);
      #1;
      checks++;
      if (bus.stall_o !== 1'b0) begin
        errors++; $display("FAIL fifo_push_stall[%0d] got %b want 0", i, bus.stall_o);
      end
      tick();
    end
    checks++;
    if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== 8'h41) begin
      errors++; $display("FAIL fifo_head got v=%b d=%h want v=1 d=41", bus.tx_valid_o, bus.tx_data_o);
    end
    bus.ldst_data_i = 32'h45;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL fifo_full_stall got %b want 1", bus.stall_o);
    end
    tick();
    bus.ldst_write_i = 1'b0; bus.ldst_addr_i = 16'hFFF1;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h12) begin
      errors++; $display("FAIL txstat_full got %h want %h", bus.ldst_data_o, 32'h12);
    end
    // Re-present the store while the host pops: still stalled, no bypass.
    bus.ldst_addr_i = 16'hFFF0; bus.ldst_write_i = 1'b1; bus.ldst_data_i = 32'h45;
    bus.tx_ready_i = 1'b1;
    #1;
    checks++;
    if (bus.stall_o !== 1'b1) begin
      errors++; $display("FAIL stall_with_pop got %b want 1", bus.stall_o);
    end
    tick();
    bus.tx_ready_i = 1'b0;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL stall_after_pop got %b want 0", bus.stall_o);
    end
    tick();
    bus.ldst_write_i = 1'b0; bus.ldst_addr_i = 16'hFFF1;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h12) begin
      errors++; $display("FAIL txstat_refill got %h want %h", bus.ldst_data_o, 32'h12);
    end
    bus.tx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h42 + 8'(i);
      checks++;
      if (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== exp_b) begin
        errors++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, bus.tx_valid_o, bus.tx_data_o, exp_b);
      end
      tick();
    end
    bus.tx_ready_i = 1'b0;
    checks++;
    if (bus.tx_valid_o !== 1'b0 || bus.tx_data_o !== 8'h00) begin
      errors++; $display("FAIL drained_empty got v=%b d=%h want v=0 d=00", bus.tx_valid_o, bus.tx_data_o);
    end
  endtask

  task automatic test_push_pop();
    bus.tx_ready_i = 1'b0;
    bus.ldst_addr_i = 16'hFFF0; bus.ldst_write_i = 1'b1;
    bus.ldst_data_i = 32'h51; tick();
    bus.ldst_data_i = 32'h52; tick();
    // Simultaneous push and pop at count 2.
    bus.ldst_data_i = 32'h53; bus.tx_ready_i = 1'b1;
    tick();
    bus.ldst_write_i = 1'b0; bus.tx_ready_i = 1'b0; bus.ldst_addr_i = 16'hFFF1;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h08) begin
      errors++; $display("FAIL pushpop_count got %h want %h", bus.ldst_data_o, 32'h08);
    end
    bus.tx_ready_i = 1'b1;
    checks++;
    if (bus.tx_data_o !== 8'h52) begin
      errors++; $display("FAIL pushpop_order0 got %h want 52", bus.tx_data_o);
    end
    tick();
    checks++;
    if (bus.tx_data_o !== 8'h53) begin
      errors++; $display("FAIL pushpop_order1 got %h want 53", bus.tx_data_o);
    end
    tick();
    bus.tx_ready_i = 1'b0;
    checks++;
    if (bus.tx_valid_o !== 1'b0) begin
      errors++; $display("FAIL pushpop_empty got %b want 0", bus.tx_valid_o);
    end
  endtask

  task automatic test_mmio_other();
    bus.ldst_addr_i = 16'h7FF5; bus.ldst_write_i = 1'b1; bus.ldst_data_i = 32'hA5A5A5A5;
    tick();
    bus.ldst_addr_i = 16'hFFF5; bus.ldst_data_i = 32'hFFFFFFFF;
    #1;
    checks++;
    if (bus.stall_o !== 1'b0) begin
      errors++; $display("FAIL other_stall got %b want 0", bus.stall_o);
    end
    tick();
    bus.ldst_write_i = 1'b0; bus.ldst_data_i = 32'h0;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h0) begin
      errors++; $display("FAIL other_read got %h want 0", bus.ldst_data_o);
    end
    bus.ldst_addr_i = 16'h7FF5;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL other_ram_intact got %h want %h", bus.ldst_data_o, 32'hA5A5A5A5);
    end
    bus.ldst_addr_i = 16'hFFF0;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h0) begin
      errors++; $display("FAIL txdata_read got %h want 0", bus.ldst_data_o);
    end
  endtask

  task automatic test_reset_midstream();
    bus.tx_ready_i = 1'b0;
    bus.ldst_addr_i = 16'hFFF0; bus.ldst_write_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ldst_data_i = 32'h61 + 32'(i);
      tick();
    end
    bus.ldst_write_i = 1'b0; bus.ldst_data_i = 32'h0; bus.ldst_addr_i = 16'h0010;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'hDEADBEEF || bus.tx_valid_o !== 1'b1) begin
      errors++; $display("FAIL pre_reset got d=%h v=%b want d=deadbeef v=1", bus.ldst_data_o, bus.tx_valid_o);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.tx_valid_o !== 1'b0 || bus.ldst_data_o !== 32'h0 || bus.tx_data_o !== 8'h00) begin
      errors++; $display("FAIL async_reset got v=%b d=%h tx=%h want v=0 d=0 tx=00", bus.tx_valid_o, bus.ldst_data_o, bus.tx_data_o);
    end
    tick();
    reset = 1'b1;
    bus.ldst_addr_i = 16'hFFF1;
    tick();
    checks++;
    if (bus.ldst_data_o !== 32'h01) begin
      errors++; $display("FAIL post_reset_stat got %h want %h", bus.ldst_data_o, 32'h01);
    end
    checks++;
    if (bus.tx_valid_o !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid got %b want 0", bus.tx_valid_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cycle();
    test_store_load();
    test_hold();
    test_fifo_full();
    test_push_pop();
    test_mmio_other();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Word-addressed data-memory responder on the execute stage's load/store port. It accepts the address, write strobe and store data the execute stage drives each cycle, and returns registered read data one cycle later. It also decodes a small MMIO window containing a console transmit FIFO to the host, a console status word and a free-running cycle counter. It can stall the pipeline when a console store meets a full FIFO.

## Interface
Parameters:
- ADDR, 16, address width (word address).
- W_OPR, 32, data width.
- DEPTH_LOG2, 10, log2 of RAM words (RAM uses ldst_addr_i[DEPTH_LOG2-1:0]).
- TXQ_LOG2, 2, log2 of console FIFO depth (4 entries).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- ldst_addr_i  in  ADDR  word address, driven every cycle.
- ldst_write_i  in  1  store strobe, one per accepted store cycle.
- ldst_data_i  in  W_OPR  store data.
- ldst_data_o  out  W_OPR  registered read data for the address presented in the previous cycle.
- hold_i  in  1  pipeline stall; freezes ldst_data_o.
- stall_o  out  1  store not accepted; requester must hold the request.
- tx_valid_o  out  1  console FIFO head valid.
- tx_data_o  out  8  console FIFO head byte.
- tx_ready_i  in  1  host accepts head.

## Operation
- Region decode:
  - ldst_addr_i[ADDR-1]=0 selects RAM.
  - =1 selects MMIO.
- MMIO registers:
  - TXDATA = all-ones−15 (0xFFF0): write pushes ldst_data_i[7:0]; read returns 0.
  - TXSTAT = 0xFFF1: read returns {zero-ext, count[TXQ_LOG2:0], full, empty} (bit0 = empty, bit1 = full, count from bit2); write ignored.
  - CYCLE = 0xFFF2: read returns 32-bit cycle counter; write ignored.
  - Any other MMIO address: read returns 0; write ignored.
- RAM:
  - Synchronous write on clk when ldst_write_i & RAM region & ~stall_o.
  - Read-during-write to the same address is write-first: the read data equals the newly written data.
  - RAM contents are not reset.
- Read path:
  - Each cycle with hold_i=0, ldst_data_o <= data selected by ldst_addr_i (RAM word or MMIO value).
  - With hold_i=1, ldst_data_o keeps its value.
- stall_o:
  - Combinational: ldst_write_i & addr==TXDATA & full.
  - Asserted even if the host pops in the same cycle; there is no pop-to-push bypass.
  - When stall_o=1, the push does not occur.
  - stall_o does not depend on hold_i.
- Console FIFO:
  - Circular, with read/write pointers plus count.
  - Push and pop may occur in the same cycle when not full; count is unchanged.
  - Pop occurs when tx_valid_o & tx_ready_i.
  - tx_valid_o = ~empty; tx_data_o = head entry (0 when empty).
- Cycle counter:
  - Increments every clk after reset and wraps at 2^32.
  - A read returns the counter value in the address cycle; it is not affected by hold_i.

## Timing
- Load latency is 1 cycle: address at cycle N produces ldst_data_o at cycle N+1, which stays valid through all hold_i cycles.
- Store to address A at N followed by a load of A at N+1 returns the new data at N+2.
- A store to TXDATA at N that is not stalled makes tx_valid_o=1 at N+1 (from empty).
- A TXSTAT read at N+1 reflects the push from N.
- Reset (asynchronous, any time):
  - ldst_data_o=0; FIFO pointers and count = 0; tx_valid_o=0; tx_data_o=0; cycle counter=0.
  - stall_o follows its equation (0 because the FIFO is empty).
  - Any in-flight FIFO contents are discarded.
- The first cycle counter value observable after reset release is 0, read at the first edge.

## Structure
- Shared params include: MMIO addresses (TXDATA, TXSTAT, CYCLE), the MMIO region-select bit and console byte width, alongside the existing ADDR and W_OPR.
- Sub-module dmem_tx_fifo (parameterised depth and width, push/pop/full/empty/count) is instantiated once. Decode, RAM array and the cycle counter stay in data_memory.

## Test plan
- Store 0xDEADBEEF to 0x0010, then load 0x0010 next cycle -> ldst_data_o=0xDEADBEEF two cycles after the store.
- Load 0x0020 (preloaded with 0x12345678) with hold_i=1 for 3 cycles while the address changes to 0x0021 -> ldst_data_o stays 0x12345678 until hold_i drops, then updates to the contents of 0x0021 one cycle later.
- Five consecutive stores to 0xFFF0 (bytes 0x41..0x45) with tx_ready_i=0 -> the fifth store sees stall_o=1 and TXSTAT reads count=4, full=1. Raising tx_ready_i for one cycle pops 0x41, and the held fifth store is accepted the next cycle.
- Push with tx_ready_i=1 and tx_valid_o=1 simultaneously at count=2 -> count stays 2 and the byte order is preserved on tx_data_o.
- Read 0xFFF2 at the 10th cycle after reset release -> value 9 appears next cycle. Reads of 0xFFF5 return 0; writes to it leave RAM address 0x7FF5 unaffected.
- Assert reset mid-stream with FIFO count=3 -> tx_valid_o=0 and ldst_data_o=0 immediately; after release TXSTAT reads empty=1, count=0.
